dibit_deframer: RTL and testbench

DIBIT_DEFRAMER -- requirements
Module: dibit_deframer

---
 rtl/dibit_deframer.sv | 143 ++++++++++++++
 tb/tb_dibit_deframer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dibit_deframer.sv
// Purpose: hunts a sync byte in a 2-bit symbol stream, reads a length byte, then queues L payload bytes.
// Latency: a payload byte completed at edge N is on byte_out from cycle N+1 when the FIFO was empty.
// Backpressure: valid/ready on the byte output; a byte arriving to a full FIFO with no pop is dropped and flagged.
module dibit_deframer #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_active,
    output logic       frame_done,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] LEN     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [1:0]    state;
    // Only the three most recent dibits are kept; the fourth comes straight from sym_in.
    logic [5:0]    window_hist;
    logic [1:0]    dcnt;
    logic [5:0]    asm_hist;
    logic [7:0]    remaining;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [7:0]    win_next;
    logic [7:0]    asm_next;
    logic          byte_done;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic          drop;

    // Datapath helpers: next sync window, next assembled byte, FIFO handshakes.
    always_comb begin
        win_next  = {window_hist, sym_in};
        asm_next  = {asm_hist, sym_in};
        byte_done = sym_valid && (state != HUNT) && (dcnt == 2'd3);
        push      = byte_done && (state == PAYLOAD);
        pop       = byte_valid && byte_ready;
        full      = (count == FULL_CNT);
        // A pop on the same edge frees the slot, so a full FIFO still takes the byte.
        accept    = push && (!full || pop);
        drop      = push && full && !pop;
    end

    // Frame state machine: sync hunt, length capture, payload countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            window_hist <= 6'd0;
            dcnt        <= 2'd0;
            asm_hist    <= 6'd0;
            remaining   <= 8'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (sym_valid) begin
                case (state)
                    HUNT: begin
                        if (win_next == SYNC_BYTE) begin
                            state       <= LEN;
                            window_hist <= 6'd0;
                            dcnt        <= 2'd0;
                        end else begin
                            window_hist <= win_next[5:0];
                        end
                    end
                    LEN: begin
                        asm_hist <= asm_next[5:0];
                        dcnt     <= dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            if (asm_next == 8'd0) begin
                                state       <= HUNT;
                                window_hist <= 6'd0;
                            end else begin
                                remaining <= asm_next;
                                state     <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        asm_hist <= asm_next[5:0];
                        dcnt     <= dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            // Dropped bytes still consume length, so the countdown is unconditional.
                            remaining <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                state       <= HUNT;
                                window_hist <= 6'd0;
                                frame_done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, the output mux hides them.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= asm_next;
    end

    assign byte_valid   = (count != '0);
    assign byte_out     = byte_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign frame_active = (state == LEN) || (state == PAYLOAD);

endmodule

// File: tb/tb_dibit_deframer.sv
// Purpose: exercises dibit_deframer with directed frames and random traffic against a byte-level model.
// Latency: model state is updated per clock edge and compared 1 time unit after the edge.
// Backpressure: byte_ready is driven fixed or random per scenario; pops are taken from the pre-edge model FIFO.
module tb_dibit_deframer;

    localparam int DEPTH = 4;
    localparam int SYNC  = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sym_in = 2'd0;
    logic       sym_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_active;
    logic       frame_done;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    dibit_deframer #(.SYNC_BYTE(8'hA5), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: byte-level view of the framing rules.
    int m_mode;      // 0 hunting, 1 expecting length, 2 in payload
    int m_win;       // last four dibits as a number 0..255
    int m_nd;        // dibits gathered of the current byte
    int m_acc;       // byte being gathered
    int m_left;      // payload bytes still expected
    int m_done;
    int m_ovf;
    int m_q[$];

    int popped[$];   // bytes actually taken from the DUT
    int done_cnt;

    // Scenario knobs
    int rdy_mode;    // 0 never ready, 1 always ready, 2 random
    int gap_mode;    // 0 no gaps, 1 alternate valid/idle, 2 random gaps

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit rst, input bit v, input int d, input bit rdy);
        bit pop;
        bit push;
        bit was_full;
        int pb;
        if (rst) begin
            m_mode = 0; m_win = 0; m_nd = 0; m_acc = 0; m_left = 0;
            m_done = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        pop = rdy && (m_q.size() > 0);
        was_full = (m_q.size() == DEPTH);
        push = 0;
        pb = 0;
        m_done = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_win = (m_win * 4 + d) % 256;
                if (m_win == SYNC) begin
                    m_mode = 1; m_nd = 0; m_acc = 0; m_win = 0;
                end
            end else begin
                m_acc = (m_acc * 4 + d) % 256;
                m_nd++;
                if (m_nd == 4) begin
                    m_nd = 0;
                    if (m_mode == 1) begin
                        if (m_acc == 0) begin
                            m_mode = 0; m_win = 0;
                        end else begin
                            m_left = m_acc; m_mode = 2;
                        end
                    end else begin
                        push = 1; pb = m_acc;
                        m_left--;
                        if (m_left == 0) begin
                            m_mode = 0; m_win = 0; m_done = 1;
                        end
                    end
                    m_acc = 0;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (was_full && !pop) m_ovf = 1;
            else m_q.push_back(pb);
        end
    endfunction

    task automatic compare_all();
        chk("byte_valid", byte_valid, (m_q.size() > 0));
        chk("byte_out", byte_out, (m_q.size() > 0) ? m_q[0] : 0);
        chk("frame_active", frame_active, (m_mode != 0));
        chk("frame_done", frame_done, m_done);
        chk("overflow", overflow, m_ovf);
    endtask

    // One clock: drive inputs, record a DUT pop, clock, update model, compare.
    task automatic step(input bit rst, input bit v, input int d);
        bit rdy;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        reset      = rst;
        sym_valid  = v;
        sym_in     = d[1:0];
        byte_ready = rdy;
        #1;
        if (!rst && byte_valid && byte_ready) popped.push_back(int'(byte_out));
        @(posedge clk);
        model_edge(rst, v, d, rdy);
        #1;
        compare_all();
        if (frame_done) done_cnt++;
    endtask

    task automatic do_reset(input bit with_valid);
        step(1'b1, with_valid, $urandom_range(0, 3));
        reset = 1'b0;
        popped.delete();
        done_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 3));
    endtask

    task automatic send_dibit(input int d);
        bit gap;
        case (gap_mode)
            0:       gap = 1'b0;
            1:       gap = 1'b1;
            default: gap = ($urandom_range(0, 3) == 0);
        endcase
        step(1'b0, 1'b1, d);
        if (gap) step(1'b0, 1'b0, $urandom_range(0, 3));
    endtask

    task automatic send_byte(input int b);
        for (int i = 3; i >= 0; i--) send_dibit((b >> (2 * i)) & 3);
    endtask

    task automatic expect_popped(input string tag, input int exp_q[$]);
        chk({tag, "_count"}, popped.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
            chk({tag, "_byte"}, popped[i], exp_q[i]);
    endtask

    initial begin
        rdy_mode = 1;
        gap_mode = 0;
        done_cnt = 0;

        // Reset with a coincident valid symbol, then explicit reset values.
        step(1'b1, 1'b1, 2);
        do_reset(1'b1);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_frame_active", frame_active, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);

        // Basic frame.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'hC3);
        idle(3);
        expect_popped("basic", '{8'h3C, 8'hC3});
        chk("basic_done_pulses", done_cnt, 1);
        chk("basic_active_after", frame_active, 1'b0);

        // Misaligned sync: one extra dibit first.
        do_reset(1'b0);
        send_dibit(1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E);
        idle(3);
        expect_popped("misalign", '{8'h7E});

        // Zero length frame.
        do_reset(1'b0);
        send_byte(8'hA5); send_byte(8'h00);
        chk("zero_active", frame_active, 1'b0);
        send_byte(8'h55);
        idle(2);
        chk("zero_pushes", popped.size(), 0);
        chk("zero_done", done_cnt, 0);

        // Overflow with consumer stalled.
        do_reset(1'b0);
        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h06);
        for (int b = 1; b <= 6; b++) send_byte(b);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_done", done_cnt, 1);
        rdy_mode = 1;
        idle(8);
        expect_popped("ovf_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
        chk("ovf_sticky", overflow, 1'b1);

        // Full FIFO with a pop on the push edge.
        do_reset(1'b0);
        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h05);
        for (int b = 1; b <= 4; b++) send_byte(b);
        step(1'b0, 1'b1, 0); step(1'b0, 1'b1, 0); step(1'b0, 1'b1, 1);
        rdy_mode = 1;
        step(1'b0, 1'b1, 1);
        idle(8);
        chk("full_pop_ovf", overflow, 1'b0);
        expect_popped("full_pop", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

        // Reset mid-payload, then a gapped frame.
        do_reset(1'b0);
        rdy_mode = 0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_dibit(2);
        do_reset(1'b1);
        chk("mid_rst_byte_out", byte_out, 8'h00);
        chk("mid_rst_byte_valid", byte_valid, 1'b0);
        chk("mid_rst_frame_active", frame_active, 1'b0);
        chk("mid_rst_overflow", overflow, 1'b0);
        rdy_mode = 1;
        gap_mode = 1;
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h9A); send_byte(8'h5B);
        gap_mode = 0;
        idle(3);
        expect_popped("gapped", '{8'h9A, 8'h5B});
        chk("gapped_done", done_cnt, 1);

        // Random traffic: frames with junk, gaps, random backpressure and the odd reset.
        rdy_mode = 2;
        gap_mode = 2;
        for (int f = 0; f < 60; f++) begin
            int len;
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(0, 1) == 1);
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) send_dibit($urandom_range(0, 3));
            send_byte(SYNC);
            len = $urandom_range(0, 7);
            send_byte(len);
            for (int j = 0; j < len; j++) send_byte($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        rdy_mode = 1;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
